// File: rtl/shadow_pkg.sv
// Shared types and defaults for the shadow-region controller.
package shadow_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ACK  = 3'd2,
    ST_HOLD = 3'd3,
    ST_TOUT = 3'd4
  } state_e;

  localparam int WAIT_W = 4;
  localparam int CNT_W  = 8;

  localparam logic [7:0] DEF_REG_BASE = {4'b1111, 4'b1110};
  localparam logic [7:0] DEF_REG_WAIT = {4'd1, 4'd1};

endpackage

// File: rtl/shadow_decode.sv
// Priority region decoder: the lowest-index enabled region whose tag matches wins.
module shadow_decode
  import shadow_pkg::*;
#(
  parameter int                     NREG     = 2,
  parameter int                     ADR_W    = 17,
  parameter int                     RB_W     = 4,
  parameter int                     IDX_W    = 1,
  parameter logic [NREG*RB_W-1:0]   REG_BASE = DEF_REG_BASE
) (
  input  logic [ADR_W-1:0] adr_i,
  input  logic [NREG-1:0]  en_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [RB_W-1:0] tag_s;
  logic [NREG-1:0] match_s;

  assign tag_s = adr_i[ADR_W-1 -: RB_W];

  // Per-region tag compare gated by the runtime enable.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < NREG; i++) begin
      match_s[i] = en_i[i] & (tag_s == REG_BASE[i*RB_W +: RB_W]);
    end
  end

  // Walk from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit_o = |match_s;
    idx_o = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      idx_o = match_s[i] ? IDX_W'(i) : idx_o;
    end
  end

endmodule

// File: rtl/shadow_ctl.sv
// Shadow-region bus controller: local regions answer with programmable wait
// states, unclaimed local accesses time out with an error, the rest go to the common bus.
module shadow_ctl
  import shadow_pkg::*;
#(
  parameter int                     NREG     = 2,
  parameter int                     ADR_W    = 17,
  parameter int                     RB_W     = 4,
  parameter logic [NREG*RB_W-1:0]   REG_BASE = DEF_REG_BASE,
  parameter logic [NREG*WAIT_W-1:0] REG_WAIT = DEF_REG_WAIT,
  parameter logic [NREG-1:0]        REG_RO   = 2'b01,
  parameter int                     TMO      = 15
) (
  input  logic             clk_p,
  input  logic             rst_n,
  input  logic [ADR_W-1:0] wb_adr_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [NREG-1:0]  region_en_i,
  input  logic             global_ack_i,
  output logic [NREG-1:0]  local_stb_o,
  output logic [NREG-1:0]  sel_o,
  output logic             bus_cyc_o,
  output logic             ack_o,
  output logic             err_o
);

  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREG-1:0]   sel_q, sel_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              lstb_en_q, lstb_en_d;
  logic              err_pend_q, err_pend_d;

  logic              hit_s;
  logic [IDX_W-1:0]  hit_idx_s;
  logic [NREG-1:0]   onehot_s;
  logic [WAIT_W-1:0] wait_sel_s;
  logic              ro_sel_s;
  logic              req_s;

  shadow_decode #(
    .NREG     (NREG),
    .ADR_W    (ADR_W),
    .RB_W     (RB_W),
    .IDX_W    (IDX_W),
    .REG_BASE (REG_BASE)
  ) u_decode (
    .adr_i (wb_adr_i),
    .en_i  (region_en_i),
    .hit_o (hit_s),
    .idx_o (hit_idx_s)
  );

  assign req_s     = wb_cyc_i & wb_stb_i;
  assign bus_cyc_o = wb_cyc_i & ~wb_adr_i[ADR_W-1];
  assign ro_sel_s  = |(onehot_s & REG_RO);

  // Per-region attributes of the decoded hit.
  always_comb begin
    onehot_s   = '0;
    wait_sel_s = '0;
    for (int i = 0; i < NREG; i++) begin
      onehot_s[i] = (hit_idx_s == IDX_W'(i));
      wait_sel_s  = wait_sel_s | (REG_WAIT[i*WAIT_W +: WAIT_W] & {WAIT_W{onehot_s[i]}});
    end
  end

  // Next-state and registered-output logic; a dropped cycle always returns to idle silently.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    lstb_en_d  = lstb_en_q;
    err_pend_d = err_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s && hit_s) begin
          state_d    = ST_WAIT;
          cnt_d      = CNT_W'(wait_sel_s);
          sel_d      = onehot_s;
          lstb_en_d  = ~(wb_we_i & ro_sel_s);
          err_pend_d = wb_we_i & ro_sel_s;
        end else if (req_s && wb_adr_i[ADR_W-1]) begin
          state_d    = ST_TOUT;
          cnt_d      = CNT_W'(TMO - 1);
          sel_d      = '0;
          lstb_en_d  = 1'b0;
          err_pend_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT, ST_TOUT: begin
        if (!wb_cyc_i) begin
          state_d   = ST_IDLE;
          lstb_en_d = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          err_d   = err_pend_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACK: begin
        state_d   = wb_cyc_i ? ST_HOLD : ST_IDLE;
        lstb_en_d = 1'b0;
      end
      ST_HOLD: begin
        if (!wb_cyc_i || !wb_stb_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        lstb_en_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      lstb_en_q  <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      lstb_en_q  <= lstb_en_d;
      err_pend_q <= err_pend_d;
    end
  end

  // Local strobe follows the CPU strobe only while the latched region is being served.
  always_comb begin
    if (((state_q == ST_WAIT) || (state_q == ST_ACK)) && lstb_en_q) begin
      local_stb_o = sel_q & {NREG{wb_stb_i}};
    end else begin
      local_stb_o = '0;
    end
  end

  assign sel_o = sel_q;
  assign err_o = err_q;
  assign ack_o = ack_q | ((state_q == ST_IDLE) & bus_cyc_o & global_ack_i);

endmodule

// File: tb/tb_shadow_ctl.sv
// Directed self-checking bench for shadow_ctl with default parameters.
module tb_shadow_ctl;

  logic        clk_p = 1'b0;
  logic        rst_n;
  logic [16:0] wb_adr_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [1:0]  region_en_i;
  logic        global_ack_i;
  logic [1:0]  local_stb_o;
  logic [1:0]  sel_o;
  logic        bus_cyc_o;
  logic        ack_o;
  logic        err_o;

  int errors = 0;
  int checks = 0;

  shadow_ctl dut (
    .clk_p        (clk_p),
    .rst_n        (rst_n),
    .wb_adr_i     (wb_adr_i),
    .wb_cyc_i     (wb_cyc_i),
    .wb_stb_i     (wb_stb_i),
    .wb_we_i      (wb_we_i),
    .region_en_i  (region_en_i),
    .global_ack_i (global_ack_i),
    .local_stb_o  (local_stb_o),
    .sel_o        (sel_o),
    .bus_cyc_o    (bus_cyc_o),
    .ack_o        (ack_o),
    .err_o        (err_o)
  );

  always #5 clk_p = ~clk_p;

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  // Issue one request, report the cycle of the first ack and what came with it.
  task automatic run_req(input logic [16:0] adr, input logic we, input int maxc,
                         output int ack_cyc, output logic err_ack,
                         output logic [1:0] lstb_or, output logic extra_ack);
    wb_adr_i = adr;
    wb_we_i  = we;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    ack_cyc  = -1;
    err_ack  = 1'b0;
    lstb_or  = 2'b00;
    for (int c = 1; c <= maxc; c++) begin
      tick();
      lstb_or = lstb_or | local_stb_o;
      if (ack_o === 1'b1) begin
        ack_cyc = c;
        err_ack = err_o;
        break;
      end
    end
    tick();
    extra_ack = ack_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    wb_adr_i     = 17'o0;
    wb_cyc_i     = 1'b0;
    wb_stb_i     = 1'b0;
    wb_we_i      = 1'b0;
    region_en_i  = 2'b11;
    global_ack_i = 1'b0;
    #2;
    checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
    checks++; if (sel_o !== 2'b00) begin errors++; $display("FAIL reset_sel: got %b want 00", sel_o); end
    checks++; if (local_stb_o !== 2'b00) begin errors++; $display("FAIL reset_lstb: got %b want 00", local_stb_o); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    int ac; logic e; logic [1:0] ls; logic xa;
    wb_adr_i = 17'o340000;
    wb_cyc_i = 1'b1;
    #1;
    checks++; if (bus_cyc_o !== 1'b0) begin errors++; $display("FAIL read_buscyc: got %b want 0", bus_cyc_o); end
    run_req(17'o340000, 1'b0, 8, ac, e, ls, xa);
    checks++; if (ac !== 3) begin errors++; $display("FAIL read_ack_cycle: got %0d want 3", ac); end
    checks++; if (ls !== 2'b01) begin errors++; $display("FAIL read_lstb: got %b want 01", ls); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL read_err: got %b want 0", e); end
    checks++; if (xa !== 1'b0) begin errors++; $display("FAIL read_ack_repeat: got %b want 0", xa); end
    checks++; if (sel_o !== 2'b01) begin errors++; $display("FAIL read_sel: got %b want 01", sel_o); end
  endtask

  task automatic test_ro_write();
    int ac; logic e; logic [1:0] ls; logic xa;
    run_req(17'o340000, 1'b1, 8, ac, e, ls, xa);
    checks++; if (ac !== 3) begin errors++; $display("FAIL rowr_ack_cycle: got %0d want 3", ac); end
    checks++; if (ls !== 2'b00) begin errors++; $display("FAIL rowr_lstb: got %b want 00", ls); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL rowr_err: got %b want 1", e); end
  endtask

  task automatic test_timeout();
    int ac; logic e; logic [1:0] ls; logic xa;
    run_req(17'o200000, 1'b0, 24, ac, e, ls, xa);
    checks++; if (ac !== 16) begin errors++; $display("FAIL tout_ack_cycle: got %0d want 16", ac); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL tout_err: got %b want 1", e); end
    checks++; if (ls !== 2'b00) begin errors++; $display("FAIL tout_lstb: got %b want 00", ls); end
  endtask

  task automatic test_cyc_drop();
    int ac; logic e; logic [1:0] ls; logic xa; logic seen;
    wb_adr_i = 17'o340000;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    tick();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      seen = seen | ack_o | err_o;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL drop_no_ack: got %b want 0", seen); end
    run_req(17'o360000, 1'b0, 8, ac, e, ls, xa);
    checks++; if (ac !== 3) begin errors++; $display("FAIL drop_next_ack_cycle: got %0d want 3", ac); end
    checks++; if (sel_o !== 2'b10) begin errors++; $display("FAIL drop_next_sel: got %b want 10", sel_o); end
    checks++; if (ls !== 2'b10) begin errors++; $display("FAIL drop_next_lstb: got %b want 10", ls); end
  endtask

  task automatic test_region_off();
    int ac; logic e; logic [1:0] ls; logic xa;
    region_en_i = 2'b00;
    run_req(17'o340000, 1'b0, 24, ac, e, ls, xa);
    checks++; if (ac !== 16) begin errors++; $display("FAIL off_ack_cycle: got %0d want 16", ac); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL off_err: got %b want 1", e); end
    wb_adr_i     = 17'o000100;
    wb_cyc_i     = 1'b1;
    wb_stb_i     = 1'b1;
    global_ack_i = 1'b0;
    #1;
    checks++; if (bus_cyc_o !== 1'b1) begin errors++; $display("FAIL glob_buscyc: got %b want 1", bus_cyc_o); end
    checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL glob_ack_lo: got %b want 0", ack_o); end
    global_ack_i = 1'b1;
    #1;
    checks++; if (ack_o !== 1'b1) begin errors++; $display("FAIL glob_ack_hi: got %b want 1", ack_o); end
    global_ack_i = 1'b0;
    wb_cyc_i     = 1'b0;
    wb_stb_i     = 1'b0;
    region_en_i  = 2'b11;
    tick();
  endtask

  task automatic test_latch();
    int ac; logic e;
    wb_adr_i = 17'o360000;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    tick();
    region_en_i = 2'b00;
    wb_adr_i    = 17'o200000;
    ac = -1;
    e  = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      tick();
      if (ack_o === 1'b1) begin
        ac = c;
        e  = err_o;
        break;
      end
    end
    checks++; if (ac !== 3) begin errors++; $display("FAIL latch_ack_cycle: got %0d want 3", ac); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL latch_err: got %b want 0", e); end
    wb_cyc_i    = 1'b0;
    wb_stb_i    = 1'b0;
    region_en_i = 2'b11;
    tick();
  endtask

  task automatic test_back_to_back();
    int ac;
    wb_adr_i = 17'o360000;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (ack_o === 1'b1) break;
    end
    tick();
    wb_stb_i = 1'b0;
    tick();
    checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL b2b_exit_ack: got %b want 0", ack_o); end
    wb_stb_i = 1'b1;
    ac = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (ack_o === 1'b1) begin
        ac = c;
        break;
      end
    end
    checks++; if (ac !== 3) begin errors++; $display("FAIL b2b_ack_cycle: got %0d want 3", ac); end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int ac; logic e; logic [1:0] ls; logic xa;
    wb_adr_i = 17'o340000;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (ack_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre_ack: got %b want 1", ack_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL rstmid_ack: got %b want 0", ack_o); end
    checks++; if (local_stb_o !== 2'b00) begin errors++; $display("FAIL rstmid_lstb: got %b want 00", local_stb_o); end
    checks++; if (sel_o !== 2'b00) begin errors++; $display("FAIL rstmid_sel: got %b want 00", sel_o); end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_req(17'o340000, 1'b0, 8, ac, e, ls, xa);
    checks++; if (ac !== 3) begin errors++; $display("FAIL rstmid_next_ack_cycle: got %0d want 3", ac); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_ro_write();
    test_timeout();
    test_cyc_drop();
    test_region_off();
    test_latch();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shadow_ctl.md
SHADOW_CTL -- requirements
Module: shadow_ctl

Interface
REQ-001 SHALL have parameter NREG, default 2: number of shadow regions, legal 1..4.
REQ-002 SHALL have parameter ADR_W, default 17: full address width, MSB is SEL.
REQ-003 SHALL have parameter RB_W, default 4: region compare width, taken from the top RB_W address bits.
REQ-004 SHALL have parameter REG_BASE, default {4'b1111,4'b1110}: packed NREG*RB_W region match values, region 0 in the LSBs.
REQ-005 SHALL have parameter REG_WAIT, default {4'd1,4'd1}: packed NREG*4 wait-state counts.
REQ-006 SHALL have parameter REG_RO, default 2'b01: per-region read-only mask.
REQ-007 SHALL have parameter TMO, default 15: unclaimed-local timeout in cycles, legal 1..255.
REQ-008 SHALL have ports: clk_p in 1, clock; rst_n in 1, asynchronous active-low reset.
REQ-009 SHALL have ports: wb_adr_i in ADR_W, address; wb_cyc_i in 1, cycle; wb_stb_i in 1, strobe; wb_we_i in 1, write.
REQ-010 SHALL have ports: region_en_i in NREG, runtime region enable; global_ack_i in 1, ack from the common bus.
REQ-011 SHALL have ports: local_stb_o out NREG, one-hot region strobe; sel_o out NREG, latched region select for the data mux.
REQ-012 SHALL have ports: bus_cyc_o out 1, common-bus cycle; ack_o out 1, cpu ack; err_o out 1, error qualifier.

Function
REQ-013 SHALL assert bus_cyc_o = wb_cyc_i & ~wb_adr_i[ADR_W-1], combinational.
REQ-014 SHALL compute hit: lowest-index enabled region whose REG_BASE equals wb_adr_i[ADR_W-1 -: RB_W].
REQ-015 SHALL use FSM states IDLE, WAIT, ACK, HOLD, TOUT.
REQ-016 SHALL, in IDLE with cyc&stb&hit, latch the region index into sel_o and load the wait counter from REG_WAIT, then go to WAIT.
REQ-017 SHALL, in WAIT, decrement the counter each cycle and go to ACK when it is 0. WAIT=0 gives ack_o 2 cycles after request; WAIT=1 gives 3.
REQ-018 SHALL, in ACK, assert ack_o for exactly 1 cycle, then go to HOLD.
REQ-019 SHALL, in HOLD, wait for stb=0, then go to IDLE; ack_o SHALL NOT repeat.
REQ-020 SHALL drive local_stb_o[sel_o] = wb_stb_i while in WAIT or ACK, and 0 otherwise.
REQ-021 SHALL treat a write to a REG_RO region as follows: normal timing, local_stb_o suppressed, err_o=1 in the ACK cycle.
REQ-022 SHALL, in IDLE with cyc&stb, SEL=1 and no hit, go to TOUT and count TMO cycles; on expiry assert ack_o and err_o for 1 cycle, then go to HOLD.
REQ-023 SHALL make ack_o = global_ack_i whenever the FSM is IDLE and bus_cyc_o=1; local ack is OR-ed in.
REQ-024 SHALL, on cyc drop in any state, go to IDLE the next cycle with no ack_o and no err_o.
REQ-025 SHALL, on address change after latch, ignore it until IDLE.
REQ-026 SHALL, on region_en_i deassertion mid-transaction, complete the latched transaction.
REQ-027 SHALL, on a new stb in the same cycle as HOLD exits, not accept it; it is accepted from IDLE the next cycle.

Reset
REQ-028 SHALL, on rst_n=0, asynchronously force state IDLE, counters 0, sel_o=0, local_stb_o=0, ack_o=0 (except the global passthrough), err_o=0.
REQ-029 SHALL, on reset mid-transaction, drop the transaction with no ack.
REQ-030 SHALL synchronously release from reset on the first clk_p edge with rst_n=1.

Structure
REQ-031 SHALL place the state enum, default REG_BASE/REG_WAIT and the wait-width constant (4) in package shadow_pkg.
REQ-032 SHALL implement the priority match in sub-module shadow_decode (address, enables -> hit, index).
REQ-033 SHALL register all outputs except bus_cyc_o, the global ack passthrough and local_stb_o.

Verification
REQ-034 SHALL cover: read adr 17'o340000, defaults -> local_stb_o=01, ack_o at cycle 3, err_o=0.
REQ-035 SHALL cover: write adr 17'o340000 -> ack_o at cycle 3, local_stb_o=00, err_o=1.
REQ-036 SHALL cover: read adr 17'o200000, no region -> ack_o and err_o together at cycle 16 (TMO=15).
REQ-037 SHALL cover: cyc dropped during WAIT -> no ack_o, next request adr 17'o360000 gives sel_o=10, ack at cycle 3.
REQ-038 SHALL cover: region_en_i=00, read 17'o340000 -> timeout path; read 17'o000100 with global_ack_i -> bus_cyc_o=1, ack_o follows global_ack_i.
REQ-039 SHALL cover: rst_n pulsed low during ACK -> ack_o=0 immediately, FSM IDLE.
